// File: rtl/analysis_ctrl.sv
// Serial peak-bin finder: scans a captured 16-bin FFT frame through one shared
// unsigned comparator and reports the index of the largest bin.
module analysis_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fft_valid,
    input  logic [DATA_W-1:0] fft_d0,
    input  logic [DATA_W-1:0] fft_d1,
    input  logic [DATA_W-1:0] fft_d2,
    input  logic [DATA_W-1:0] fft_d3,
    input  logic [DATA_W-1:0] fft_d4,
    input  logic [DATA_W-1:0] fft_d5,
    input  logic [DATA_W-1:0] fft_d6,
    input  logic [DATA_W-1:0] fft_d7,
    input  logic [DATA_W-1:0] fft_d8,
    input  logic [DATA_W-1:0] fft_d9,
    input  logic [DATA_W-1:0] fft_d10,
    input  logic [DATA_W-1:0] fft_d11,
    input  logic [DATA_W-1:0] fft_d12,
    input  logic [DATA_W-1:0] fft_d13,
    input  logic [DATA_W-1:0] fft_d14,
    input  logic [DATA_W-1:0] fft_d15,
    output logic [3:0]        freq,
    output logic              done,
    output logic              busy,
    output logic              overrun
);

    // state  | meaning
    // IDLE   | waiting for a frame
    // SCAN   | comparing bin idx against the running maximum
    // DONE   | one-cycle result strobe; may accept the next frame
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [3:0]        idx;
    logic [3:0]        best_idx;
    logic [DATA_W-1:0] best_val;
    logic [DATA_W-1:0] frame_buf [16];
    logic [DATA_W-1:0] cur;
    logic              cur_gt;
    logic              accept;

    assign accept = fft_valid && (state != S_SCAN);
    assign cur    = frame_buf[idx];
    assign cur_gt = cur > best_val;
    assign done   = (state == S_DONE);
    assign busy   = (state == S_SCAN);

    // Buffer has no reset; it is only meaningful after an accepted frame.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            frame_buf[0]  <= fft_d0;
            frame_buf[1]  <= fft_d1;
            frame_buf[2]  <= fft_d2;
            frame_buf[3]  <= fft_d3;
            frame_buf[4]  <= fft_d4;
            frame_buf[5]  <= fft_d5;
            frame_buf[6]  <= fft_d6;
            frame_buf[7]  <= fft_d7;
            frame_buf[8]  <= fft_d8;
            frame_buf[9]  <= fft_d9;
            frame_buf[10] <= fft_d10;
            frame_buf[11] <= fft_d11;
            frame_buf[12] <= fft_d12;
            frame_buf[13] <= fft_d13;
            frame_buf[14] <= fft_d14;
            frame_buf[15] <= fft_d15;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= 4'd0;
            best_val <= '0;
            best_idx <= 4'd0;
            freq     <= 4'd0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fft_valid) begin
                        state <= S_SCAN;
                        idx   <= 4'd0;
                    end
                end
                S_SCAN: begin
                    if (fft_valid) overrun <= 1'b1;
                    if (idx == 4'd0) begin
                        best_val <= cur;
                        best_idx <= 4'd0;
                    end else if (cur_gt) begin
                        best_val <= cur;
                        best_idx <= idx;
                    end
                    // Last compare feeds freq directly so it lands with done.
                    if (idx == 4'd15) begin
                        state <= S_DONE;
                        idx   <= 4'd0;
                        freq  <= cur_gt ? 4'd15 : best_idx;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                S_DONE: begin
                    idx <= 4'd0;
                    if (fft_valid) state <= S_SCAN;
                    else           state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
